// File: rtl/stack_mem_access_unit_pkg.sv
// Shared definitions for the stack/memory access unit: op codes, FSM states,
// result routing tags and stack geometry helpers.
package stack_mem_access_unit_pkg;

    // Decoded memory-stage operations; codes 9..15 behave as NOP.
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } op_e;

    // Sequencer states for the two-cycle INT/RTI operations.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INT_FLAGS = 2'd1,
        ST_RTI_PC    = 2'd2
    } state_e;

    // Which result register a read cycle feeds.
    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_RD    = 2'd1,
        RES_PC    = 2'd2,
        RES_FLAGS = 2'd3
    } res_e;

    // Words occupied by one stack entry (one 32-bit transfer).
    localparam int ENTRY_WORDS         = 2;
    localparam int NUM_OF_REGISTER_DEF = 11;

    // Empty-stack pointer value: one past the top word of memory.
    function automatic logic [63:0] sp_reset_value(input int n);
        return 64'd1 << n;
    endfunction

    localparam logic [63:0] SP_RESET = sp_reset_value(NUM_OF_REGISTER_DEF);

endpackage

// File: rtl/stack_mem_access_unit_stack_pointer_unit.sv
// Stack pointer register for a full-descending stack with two-word entries.
// Provides the push/pop access addresses and flags out-of-range accesses;
// an out-of-range access leaves the pointer unchanged.
module stack_pointer_unit
    import stack_mem_access_unit_pkg::*;
#(
    parameter int address_width   = 32,
    parameter int num_of_register = NUM_OF_REGISTER_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_req,
    input  logic                     pop_req,
    output logic [address_width-1:0] sp,
    output logic [address_width-1:0] push_addr,
    output logic [address_width-1:0] pop_addr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [63:0]              SP_TOP_64 = sp_reset_value(num_of_register);
    localparam logic [address_width-1:0] SP_TOP    = SP_TOP_64[address_width-1:0];
    localparam logic [address_width-1:0] ENTRY     = address_width'(ENTRY_WORDS);

    logic [address_width-1:0] sp_q;
    logic [address_width-1:0] sp_d;

    assign sp        = sp_q;
    assign push_addr = sp_q - ENTRY;
    assign pop_addr  = sp_q;

    // Bounds check: a push needs two free words below sp, a pop needs a full entry above.
    always_comb begin
        overflow  = push_req && (sp_q < ENTRY);
        underflow = pop_req && (sp_q > (SP_TOP - ENTRY));
    end

    // Next stack pointer: move by one entry only when the access is in range.
    always_comb begin
        sp_d = sp_q;
        if (push_req && !overflow) begin
            sp_d = sp_q - ENTRY;
        end else if (pop_req && !underflow) begin
            sp_d = sp_q + ENTRY;
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register; reset means empty stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/stack_mem_access_unit.sv
// Memory-stage initiator: turns decoded LOAD/STORE/stack ops into memory
// requests, sequences INT/RTI over two cycles, and returns load/pop data,
// restored PC and restored flags as one-cycle pulses.
module stack_mem_access_unit
    import stack_mem_access_unit_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int address_width   = 32,
    parameter int num_of_register = NUM_OF_REGISTER_DEF,
    parameter int flag_width      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_valid,
    input  logic [3:0]                op,
    input  logic [address_width-1:0]  ea,
    input  logic [2*data_width-1:0]   wdata,
    input  logic [flag_width-1:0]     flags_in,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [address_width-1:0]  mem_addr,
    output logic [2*data_width-1:0]   mem_wdata,
    input  logic [2*data_width-1:0]   mem_rdata,
    output logic                      busy,
    output logic [2*data_width-1:0]   rd_data,
    output logic                      rd_valid,
    output logic [2*data_width-1:0]   pc_out,
    output logic                      pc_valid,
    output logic [flag_width-1:0]     flags_out,
    output logic                      flags_valid,
    output logic [address_width-1:0]  sp,
    output logic                      stack_err
);

    localparam int DW2 = 2 * data_width;

    state_e                   state_q, state_d;
    logic [flag_width-1:0]    flags_lat_q, flags_lat_d;
    logic [DW2-1:0]           rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DW2-1:0]           pc_q, pc_d;
    logic                     pc_valid_q, pc_valid_d;
    logic [flag_width-1:0]    flags_q, flags_d;
    logic                     flags_valid_q, flags_valid_d;
    logic                     stack_err_q, stack_err_d;

    logic                     push_s, pop_s, load_s, store_s;
    logic [DW2-1:0]           push_data_s;
    res_e                     res_kind_s;
    logic [address_width-1:0] push_addr_s, pop_addr_s;
    logic                     ovf_s, udf_s;
    logic [DW2-1:0]           read_val_s;

    stack_pointer_unit #(
        .address_width   (address_width),
        .num_of_register (num_of_register)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .push_req  (push_s),
        .pop_req   (pop_s),
        .sp        (sp),
        .push_addr (push_addr_s),
        .pop_addr  (pop_addr_s),
        .overflow  (ovf_s),
        .underflow (udf_s)
    );

    assign busy        = (state_q != ST_IDLE);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign pc_out      = pc_q;
    assign pc_valid    = pc_valid_q;
    assign flags_out   = flags_q;
    assign flags_valid = flags_valid_q;
    assign stack_err   = stack_err_q;

    // Op decode and INT/RTI sequencing: which access happens this cycle and where its data goes.
    always_comb begin
        state_d     = state_q;
        flags_lat_d = flags_lat_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        store_s     = 1'b0;
        push_data_s = {DW2{1'b0}};
        res_kind_s  = RES_NONE;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_LOAD: begin
                            load_s     = 1'b1;
                            res_kind_s = RES_RD;
                        end
                        OP_STORE: begin
                            store_s = 1'b1;
                        end
                        OP_PUSH, OP_CALL: begin
                            push_s      = 1'b1;
                            push_data_s = wdata;
                        end
                        OP_POP: begin
                            pop_s      = 1'b1;
                            res_kind_s = RES_RD;
                        end
                        OP_RET: begin
                            pop_s      = 1'b1;
                            res_kind_s = RES_PC;
                        end
                        OP_INT: begin
                            push_s      = 1'b1;
                            push_data_s = wdata;
                            flags_lat_d = flags_in;
                            state_d     = ST_INT_FLAGS;
                        end
                        OP_RTI: begin
                            pop_s      = 1'b1;
                            res_kind_s = RES_FLAGS;
                            state_d    = ST_RTI_PC;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INT_FLAGS: begin
                push_s      = 1'b1;
                push_data_s = {{(DW2-flag_width){1'b0}}, flags_lat_q};
                state_d     = ST_IDLE;
            end
            ST_RTI_PC: begin
                pop_s      = 1'b1;
                res_kind_s = RES_PC;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory request: at most one of write/read, suppressed on stack bounds violations.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = {address_width{1'b0}};
        mem_wdata = {DW2{1'b0}};
        if (load_s) begin
            mem_re   = 1'b1;
            mem_addr = ea;
        end else if (store_s) begin
            mem_we    = 1'b1;
            mem_addr  = ea;
            mem_wdata = wdata;
        end else if (push_s) begin
            mem_we    = !ovf_s;
            mem_addr  = push_addr_s;
            mem_wdata = push_data_s;
        end else if (pop_s) begin
            mem_re   = !udf_s;
            mem_addr = pop_addr_s;
        end else begin
            mem_addr = {address_width{1'b0}};
        end
    end

    // Result capture: route read data (zero on underflow) to its register and raise one pulse.
    always_comb begin
        read_val_s    = (pop_s && udf_s) ? {DW2{1'b0}} : mem_rdata;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        pc_d          = pc_q;
        pc_valid_d    = 1'b0;
        flags_d       = flags_q;
        flags_valid_d = 1'b0;
        stack_err_d   = stack_err_q | ovf_s | udf_s;
        case (res_kind_s)
            RES_RD: begin
                rd_data_d  = read_val_s;
                rd_valid_d = 1'b1;
            end
            RES_PC: begin
                pc_d       = read_val_s;
                pc_valid_d = 1'b1;
            end
            RES_FLAGS: begin
                flags_d       = read_val_s[flag_width-1:0];
                flags_valid_d = 1'b1;
            end
            default: begin
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // State, latched flags, result registers and sticky stack error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            flags_lat_q   <= {flag_width{1'b0}};
            rd_data_q     <= {DW2{1'b0}};
            rd_valid_q    <= 1'b0;
            pc_q          <= {DW2{1'b0}};
            pc_valid_q    <= 1'b0;
            flags_q       <= {flag_width{1'b0}};
            flags_valid_q <= 1'b0;
            stack_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_lat_q   <= flags_lat_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            stack_err_q   <= stack_err_d;
        end
    end

endmodule

// File: tb/tb_stack_mem_access_unit.sv
// Self-checking bench: directed scenarios plus randomized ops checked every
// cycle against a queue-based stack model and a word-array memory model.
module tb_stack_mem_access_unit;
    import stack_mem_access_unit_pkg::*;

    localparam int SPR = 2048;
    localparam int CAP = SPR / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] ea, wdata, mem_rdata;
    logic [3:0]  flags_in;
    logic        mem_we, mem_re, busy, rd_valid, pc_valid, flags_valid, stack_err;
    logic [31:0] mem_addr, mem_wdata, rd_data, pc_out, sp;
    logic [3:0]  flags_out;

    logic        s_op_valid;
    logic [3:0]  s_op;
    logic [31:0] s_wdata, s_mem_rdata;
    logic        s_mem_we, s_mem_re, s_busy, s_rd_valid, s_pc_valid, s_flags_valid, s_stack_err;
    logic [31:0] s_mem_addr, s_mem_wdata, s_rd_data, s_pc_out, s_sp;
    logic [3:0]  s_flags_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stack_mem_access_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .ea(ea), .wdata(wdata),
        .flags_in(flags_in), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .rd_data(rd_data),
        .rd_valid(rd_valid), .pc_out(pc_out), .pc_valid(pc_valid), .flags_out(flags_out),
        .flags_valid(flags_valid), .sp(sp), .stack_err(stack_err)
    );

    stack_mem_access_unit #(.num_of_register(3)) u_small (
        .clk(clk), .rst(rst), .op_valid(s_op_valid), .op(s_op), .ea(32'h0), .wdata(s_wdata),
        .flags_in(4'h0), .mem_we(s_mem_we), .mem_re(s_mem_re), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .busy(s_busy), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .pc_out(s_pc_out), .pc_valid(s_pc_valid), .flags_out(s_flags_out),
        .flags_valid(s_flags_valid), .sp(s_sp), .stack_err(s_stack_err)
    );

    // Memory: 2048 x 16-bit words, high word at the lower address, wraps.
    logic [15:0] mem [0:2047];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[10:0]]         <= mem_wdata[31:16];
            mem[mem_addr[10:0] + 11'd1] <= mem_wdata[15:0];
        end
    end
    always @(negedge clk) begin
        mem_rdata <= mem_re ? {mem[mem_addr[10:0]], mem[mem_addr[10:0] + 11'd1]} : 32'h0;
    end

    // Reference model: stack as a queue of entries, memory as a word array.
    logic [31:0] q[$];
    logic [15:0] mm [0:2047];
    bit          int_pend, rti_pend;
    logic [3:0]  int_fl;
    bit          e_we, e_re, e_busy, e_err, e_rdv, e_pcv, e_flv;
    logic [31:0] e_addr, e_wdata, e_sp, e_rdd, e_pc;
    logic [3:0]  e_fl;
    bit          n_err, n_rdv, n_pcv, n_flv;
    logic [31:0] n_rdd, n_pc;
    logic [3:0]  n_fl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        int_pend = 1'b0; rti_pend = 1'b0; int_fl = 4'h0;
        n_err = 1'b0; n_rdv = 1'b0; n_pcv = 1'b0; n_flv = 1'b0;
        n_rdd = 32'h0; n_pc = 32'h0; n_fl = 4'h0;
    endtask

    task automatic do_push(input logic [31:0] val);
        if (q.size() >= CAP) begin
            n_err = 1'b1;
        end else begin
            e_we    = 1'b1;
            e_addr  = 32'(SPR - 2 * (q.size() + 1));
            e_wdata = val;
            q.push_back(val);
        end
    endtask

    task automatic do_pop(output logic [31:0] val);
        if (q.size() == 0) begin
            n_err = 1'b1;
            val   = 32'h0;
        end else begin
            e_re   = 1'b1;
            e_addr = 32'(SPR - 2 * q.size());
            val    = q.pop_back();
        end
    endtask

    // One clock cycle: publish last cycle's results, drive the op, predict this cycle.
    task automatic step(input bit v, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] f);
        logic [31:0] val;
        @(posedge clk); #1;
        e_rdv = n_rdv; e_rdd = n_rdd; e_pcv = n_pcv; e_pc = n_pc;
        e_flv = n_flv; e_fl = n_fl;   e_err = n_err;
        e_sp  = 32'(SPR - 2 * q.size());
        n_rdv = 1'b0; n_pcv = 1'b0; n_flv = 1'b0;
        op_valid = v; op = o; ea = a; wdata = d; flags_in = f;
        e_we = 1'b0; e_re = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
        e_busy = int_pend || rti_pend;
        if (int_pend) begin
            do_push({28'h0, int_fl});
            int_pend = 1'b0;
        end else if (rti_pend) begin
            do_pop(val);
            n_pcv = 1'b1; n_pc = val;
            rti_pend = 1'b0;
        end else if (v) begin
            case (o)
                OP_LOAD: begin
                    e_re = 1'b1; e_addr = a;
                    n_rdv = 1'b1; n_rdd = {mm[a[10:0]], mm[a[10:0] + 11'd1]};
                end
                OP_STORE: begin
                    e_we = 1'b1; e_addr = a; e_wdata = d;
                    mm[a[10:0]] = d[31:16]; mm[a[10:0] + 11'd1] = d[15:0];
                end
                OP_PUSH, OP_CALL: do_push(d);
                OP_POP: begin do_pop(val); n_rdv = 1'b1; n_rdd = val; end
                OP_RET: begin do_pop(val); n_pcv = 1'b1; n_pc = val; end
                OP_INT: begin do_push(d); int_pend = 1'b1; int_fl = f; end
                OP_RTI: begin do_pop(val); n_flv = 1'b1; n_fl = val[3:0]; rti_pend = 1'b1; end
                default: ;
            endcase
        end
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            if (e_we || e_re) chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("sp", sp, e_sp);
            chk("stack_err", 32'(stack_err), 32'(e_err));
            chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
            chk("rd_data", rd_data, e_rdd);
            chk("pc_valid", 32'(pc_valid), 32'(e_pcv));
            chk("pc_out", pc_out, e_pc);
            chk("flags_valid", 32'(flags_valid), 32'(e_flv));
            chk("flags_out", 32'(flags_out), 32'(e_fl));
        end
    end

    initial begin
        int r;
        rst = 1'b1; op_valid = 1'b0; op = 4'h0; ea = 32'h0; wdata = 32'h0; flags_in = 4'h0;
        s_op_valid = 1'b0; s_op = 4'h0; s_wdata = 32'h0; s_mem_rdata = 32'h0;
        for (int i = 0; i < 2048; i++) begin mem[i] = 16'h0; mm[i] = 16'h0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp", sp, 32'd2048);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_small_sp", s_sp, 32'd8);
        rst = 1'b0;

        // Store then load back.
        step(1'b1, OP_STORE, 32'h10, 32'hDEADBEEF, 4'h0); #1;
        chk("t1_store_we", 32'(mem_we), 32'd1);
        chk("t1_store_addr", mem_addr, 32'h10);
        step(1'b1, OP_LOAD, 32'h10, 32'h0, 4'h0);
        step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t1_load_valid", 32'(rd_valid), 32'd1);
        chk("t1_load_data", rd_data, 32'hDEADBEEF);

        // Two pushes, two pops.
        step(1'b1, OP_PUSH, 32'h0, 32'h11112222, 4'h0); #1;
        chk("t2_push1_addr", mem_addr, 32'd2046);
        step(1'b1, OP_PUSH, 32'h0, 32'h33334444, 4'h0); #1;
        chk("t2_push2_addr", mem_addr, 32'd2044);
        step(1'b1, OP_POP, 32'h0, 32'h0, 4'h0);
        step(1'b1, OP_POP, 32'h0, 32'h0, 4'h0); #1;
        chk("t2_pop1_data", rd_data, 32'h33334444);
        step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t2_pop2_data", rd_data, 32'h11112222);
        chk("t2_sp", sp, 32'd2048);

        // INT then RTI.
        step(1'b1, OP_INT, 32'h0, 32'h00000100, 4'b1010); #1;
        chk("t3_int_pc_addr", mem_addr, 32'd2046);
        step(1'b1, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t3_int_busy", 32'(busy), 32'd1);
        chk("t3_int_fl_wdata", mem_wdata, 32'h0000000A);
        step(1'b1, OP_RTI, 32'h0, 32'h0, 4'h0);
        step(1'b1, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t3_flags_out", 32'(flags_out), 32'hA);
        step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t3_pc_out", pc_out, 32'h100);
        chk("t3_sp", sp, 32'd2048);

        // Pop on empty stack.
        step(1'b1, OP_POP, 32'h0, 32'h0, 4'h0); #1;
        chk("t4_no_re", 32'(mem_re), 32'd0);
        step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0); #1;
        chk("t4_err", 32'(stack_err), 32'd1);
        chk("t4_rd_valid", 32'(rd_valid), 32'd1);
        chk("t4_rd_data", rd_data, 32'h0);

        // Reset in the middle of INT.
        step(1'b1, OP_INT, 32'h0, 32'h00000200, 4'h5);
        @(posedge clk); #1;
        chk_en = 1'b0;
        op_valid = 1'b0;
        chk("t6_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sp", sp, 32'd2048);
        chk("t6_err", 32'(stack_err), 32'd0);
        chk("t6_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("t6_we_hold", 32'(mem_we), 32'd0);
        rst = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom % 12);
            step(($urandom % 8) != 0, (r < 9) ? 4'(r) : 4'($urandom_range(9, 15)),
                 32'($urandom_range(0, 998)), $urandom, 4'($urandom));
        end
        repeat (3) step(1'b0, OP_NOP, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk_en = 1'b0;

        // Overflow on a small (8-word) stack.
        chk("t5_sp_start", s_sp, 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_op_valid = 1'b1; s_op = OP_PUSH; s_wdata = 32'(i); #1;
            if (i < 4) begin
                chk("t5_push_we", 32'(s_mem_we), 32'd1);
                chk("t5_push_addr", s_mem_addr, 32'(6 - 2 * i));
                chk("t5_err_clear", 32'(s_stack_err), 32'd0);
            end else begin
                chk("t5_ovf_we", 32'(s_mem_we), 32'd0);
            end
        end
        @(posedge clk); #1;
        s_op_valid = 1'b0; #1;
        chk("t5_err", 32'(s_stack_err), 32'd1);
        chk("t5_sp_end", s_sp, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
